gpio_in: RTL

- Memory-mapped GPIO input port; the receive-side counterpart of the GPIO output peripheral.
- Samples external input pins (buttons/switches) through a 2-flop synchronizer and a per-pin debounce filter.
- Detects rising/falling edges on the debounced value, latches them in a write-1-to-clear status register, and raises a level interrupt to the core.
- Sits on the same peripheral write/read port as the other perips.

---
 rtl/gpio_in.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/gpio_in.sv
// gpio_in: memory-mapped GPIO input port.
// Each raw pin is mapped to a logical level, passed through a 2-flop
// synchronizer and a per-pin debounce filter. Edges on the debounced value
// are latched into a write-1-to-clear STATUS register, and that register
// drives a level interrupt.
//
// Ports:
//   clk_i        clock
//   rst_n_i      asynchronous active-low reset
//   wen_i        write enable
//   waddr_i      write address (decoded on [4:0])
//   wdata_i      write data
//   raddr_i      read address (decoded on [4:0], registered)
//   rdata_o      read data, valid the cycle after raddr_i
//   gpio_pins_i  raw asynchronous input pins
//   irq_o        level interrupt, |(STATUS & IRQ_EN)
//
// Register map (addr[4:0]):
//   0x00 DATA (RO), 0x04 IRQ_EN, 0x08 RISE_EN, 0x0C FALL_EN, 0x10 STATUS (W1C)
module gpio_in #(
  parameter int unsigned NPINS        = 4,
  parameter int unsigned DEBOUNCE_CYC = 16,
  parameter bit          ACTIVE_LOW   = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             wen_i,
  input  logic [31:0]      waddr_i,
  input  logic [31:0]      wdata_i,
  input  logic [31:0]      raddr_i,
  output logic [31:0]      rdata_o,
  input  logic [NPINS-1:0] gpio_pins_i,
  output logic             irq_o
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned OFS_W  = 5;
  localparam int unsigned CNT_W  = $clog2(DEBOUNCE_CYC) + 1;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYC - 1);

  localparam logic [OFS_W-1:0] OFS_DATA    = 5'h00;
  localparam logic [OFS_W-1:0] OFS_IRQ_EN  = 5'h04;
  localparam logic [OFS_W-1:0] OFS_RISE_EN = 5'h08;
  localparam logic [OFS_W-1:0] OFS_FALL_EN = 5'h0C;
  localparam logic [OFS_W-1:0] OFS_STATUS  = 5'h10;

  logic [NPINS-1:0] s1_q, s2_q;
  logic [NPINS-1:0] deb_q, deb_d;
  logic [CNT_W-1:0] cnt_q [NPINS];
  logic [CNT_W-1:0] cnt_d [NPINS];
  logic [NPINS-1:0] irq_en_q, irq_en_d;
  logic [NPINS-1:0] rise_en_q, rise_en_d;
  logic [NPINS-1:0] fall_en_q, fall_en_d;
  logic [NPINS-1:0] status_q, status_d;
  logic [OFS_W-1:0] raddr_q;

  logic [NPINS-1:0] pin_logical_c;
  logic [NPINS-1:0] edge_set_c;
  logic [NPINS-1:0] status_clr_c;
  logic [OFS_W-1:0] wofs_c;
  logic             unused_c;

  // Upper address bits are not decoded; wdata upper bits are dropped.
  assign unused_c = ^{waddr_i[31:OFS_W], raddr_i[31:OFS_W], wdata_i};

  // Polarity mapping ahead of the synchronizer.
  assign pin_logical_c = ACTIVE_LOW ? ~gpio_pins_i : gpio_pins_i;

  // Debounce: accept a new level only after DEBOUNCE_CYC consecutive
  // differing samples; any agreeing sample restarts the count.
  always_comb begin
    deb_d = deb_q;
    for (int i = 0; i < int'(NPINS); i++) begin
      cnt_d[i] = cnt_q[i];
      if (s2_q[i] == deb_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_MAX) begin
        deb_d[i] = s2_q[i];
        cnt_d[i] = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  // Edge capture uses the enables in force before this edge.
  assign edge_set_c = (~deb_q &  deb_d & rise_en_q)
                    | ( deb_q & ~deb_d & fall_en_q);

  // Register write decode; a same-cycle edge set overrides the W1C clear.
  assign wofs_c       = waddr_i[OFS_W-1:0];
  assign status_clr_c = (wen_i && wofs_c == OFS_STATUS) ? wdata_i[NPINS-1:0] : '0;

  always_comb begin
    irq_en_d  = irq_en_q;
    rise_en_d = rise_en_q;
    fall_en_d = fall_en_q;
    status_d  = (status_q & ~status_clr_c) | edge_set_c;
    if (wen_i) begin
      case (wofs_c)
        OFS_IRQ_EN:  irq_en_d  = wdata_i[NPINS-1:0];
        OFS_RISE_EN: rise_en_d = wdata_i[NPINS-1:0];
        OFS_FALL_EN: fall_en_d = wdata_i[NPINS-1:0];
        default:     ;
      endcase
    end
  end

  // State registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      s1_q      <= '0;
      s2_q      <= '0;
      deb_q     <= '0;
      irq_en_q  <= '0;
      rise_en_q <= '0;
      fall_en_q <= '0;
      status_q  <= '0;
      raddr_q   <= '0;
      for (int i = 0; i < int'(NPINS); i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      s1_q      <= pin_logical_c;
      s2_q      <= s1_q;
      deb_q     <= deb_d;
      irq_en_q  <= irq_en_d;
      rise_en_q <= rise_en_d;
      fall_en_q <= fall_en_d;
      status_q  <= status_d;
      raddr_q   <= raddr_i[OFS_W-1:0];
      for (int i = 0; i < int'(NPINS); i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  // Read mux from the registered address and current register contents.
  always_comb begin
    rdata_o = '0;
    case (raddr_q)
      OFS_DATA:    rdata_o = DATA_W'(deb_q);
      OFS_IRQ_EN:  rdata_o = DATA_W'(irq_en_q);
      OFS_RISE_EN: rdata_o = DATA_W'(rise_en_q);
      OFS_FALL_EN: rdata_o = DATA_W'(fall_en_q);
      OFS_STATUS:  rdata_o = DATA_W'(status_q);
      default:     rdata_o = '0;
    endcase
  end

  assign irq_o = |(status_q & irq_en_q);

endmodule
